// File: rtl/multi_port_regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package multi_port_regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Ceiling log2, used to derive the address width from the register count.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_port_regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, flush zeroes all.
module regfile_scoreboard
  import multi_port_regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned NREAD = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                set_i,
  input  logic [AW-1:0]       set_addr_i,
  input  logic                clr_i,
  input  logic [AW-1:0]       clr_addr_i,
  input  logic [NREAD*AW-1:0] look_addr_i,
  output logic [NREAD-1:0]    busy_c_o
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Issue is applied after writeback so a same-cycle pair leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (clr_i) pend_d[clr_addr_i] = 1'b0;
      if (set_i) pend_d[set_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar g = 0; g < int'(NREAD); g++) begin : g_look
    assign busy_c_o[g] = pend_q[look_addr_i[g*AW +: AW]];
  end

endmodule

// File: rtl/multi_port_regfile.sv
// Parametrised register file: r0 hard-wired to zero, write-first bypass,
// pending scoreboard and a one-entry-per-cycle clear sequencer.
module multi_port_regfile
  import multi_port_regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  output logic                   ready,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic                   iss,
  input  logic [AW-1:0]          iss_a
);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             sb_flush;
  logic             sb_set;
  logic             sb_clr;
  logic [NREAD-1:0] sb_busy;
  logic             idle;

  assign idle  = (state_q == ST_IDLE);
  assign ready = idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer and array/scoreboard write control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    mem_wa   = cnt_q;
    mem_wd   = '0;
    sb_flush = 1'b0;
    sb_set   = 1'b0;
    sb_clr   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (clr) begin
          cnt_d    = AW'(1);
          sb_flush = 1'b1;
        end else if (cnt_q == AW'(DEPTH - 1)) begin
          cnt_d   = AW'(1);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d  = ST_CLEAR;
          cnt_d    = AW'(1);
          sb_flush = 1'b1;
        end else begin
          mem_we = we && (wa != '0);
          mem_wa = wa;
          mem_wd = wd;
          sb_clr = mem_we;
          sb_set = iss && (iss_a != '0);
        end
      end
    endcase
  end

  // No reset on the array so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  regfile_scoreboard #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .NREAD(NREAD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (sb_flush),
    .set_i      (sb_set),
    .set_addr_i (iss_a),
    .clr_i      (sb_clr),
    .clr_addr_i (wa),
    .look_addr_i(ra),
    .busy_c_o   (sb_busy)
  );

  for (genvar g = 0; g < int'(NREAD); g++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero;
    logic          hit;
    assign addr = ra[g*AW +: AW];
    assign zero = !idle || (addr == '0);
    assign hit  = we && (wa == addr);
    assign rd[g*WIDTH +: WIDTH] = zero ? '0 : (hit ? wd : mem_q[addr]);
    assign rbusy[g]             = !zero && sb_busy[g];
  end

endmodule

// File: doc/multi_port_regfile.md
# multi_port_regfile

Parametrised successor to the processor's 8×16 register file: configurable data width, register count and number of read ports; register 0 hard-wired to zero; write-first bypass on every read port; a per-register pending (scoreboard) bit for multi-cycle producers; and a self-sequenced clear that zeroes the array one entry per cycle after reset or on request. Sits in the decode stage between instruction decode (read and issue) and writeback (write).

## Interface
Parameters:
- WIDTH, 16, data width in bits
- DEPTH, 8, number of registers; power of two, ≥ 2
- AW, log2(DEPTH), address width (derived)
- NREAD, 2, number of read ports, ≥ 1

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- clr  in  1  request a full array clear (sampled on clk)
- ready  out  1  high when the array is usable (IDLE state)
- ra  in  NREAD*AW  read addresses, port i at bits [i*AW +: AW]
- rd  out  NREAD*WIDTH  read data, port i at bits [i*WIDTH +: WIDTH]
- rbusy  out  NREAD  pending bit of the register addressed by port i
- we  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  WIDTH  writeback data
- iss  in  1  mark a register pending (multi-cycle producer issued)
- iss_a  in  AW  register to mark pending

## Operation
- States: CLEAR, IDLE.
- Reset asserted, asynchronously: state=CLEAR, clear counter cnt=1, all pending bits=0, ready=0. Array contents are not reset directly.
- CLEAR: each edge writes m[cnt]=0 and increments cnt. At the edge where cnt==DEPTH-1, that entry is written and state→IDLE. we and iss are ignored. All rd read 0 and all rbusy read 0. clr re-asserted here restarts at cnt=1.
- IDLE with clr=1: next edge enters CLEAR with cnt=1 and clears all pending bits. we and iss in that cycle are ignored.
- Reads, combinational, in IDLE:
  - ra_i==0 → rd_i=0 and rbusy_i=0.
  - Otherwise, if we && wa==ra_i && wa!=0 → rd_i=wd (bypass). Else rd_i=m[ra_i].
  - rbusy_i is the stored pending bit of ra_i. It is not bypassed.
- Write, IDLE: we && wa!=0 → m[wa]=wd and pending[wa]=0 at the edge. wa==0 is ignored.
- Issue, IDLE: iss && iss_a!=0 → pending[iss_a]=1 at the edge. iss_a==0 is ignored.
- Simultaneous write and issue to the same non-zero address: the data is written, and the pending bit ends up 1 (issue wins).
- Multiple read ports may address the same register. Each port returns identical data.

## Timing
- Read data and rbusy: zero-cycle combinational paths from ra, we, wa, wd.
- Write and issue take effect at the next rising edge, i.e. visible from the stored array one cycle later. Through the bypass, write data is visible in the same cycle.
- Clear duration: ready rises exactly DEPTH-1 edges after reset deasserts. With DEPTH=8 that is 7 edges. After a clr pulse in IDLE it is DEPTH edges, i.e. 8.
- Reset asserted mid-clear or mid-operation: immediate return to CLEAR with cnt=1, pending=0, ready=0.
- Reset values: ready=0, rbusy=0, rd=0.

## Structure
- A shared package holds the state encoding (CLEAR, IDLE) and a clog2 helper function used to derive AW.
- One natural sub-module: regfile_scoreboard. It holds the DEPTH pending bits with set/clear/flush and NREAD lookup ports, and uses the same async reset.
- Array, bypass muxes and clear sequencer stay in the top level. The array has no reset, so it can map to distributed RAM.

## Test plan
- Reset release, DEPTH=8: ready goes 0→1 after exactly 7 edges; afterwards every ra 0..7 reads 0x0000.
- Write wa=3, wd=0xBEEF with ra0=3 in the same cycle: rd0=0xBEEF (bypass). Next cycle with we=0: rd0=0xBEEF from the array. Write to wa=0 with 0x1234: ra=0 still reads 0x0000.
- iss iss_a=5 → rbusy for ra=5 is 1 next cycle. Then we wa=5 wd=0x0042 → rbusy=0 next cycle and rd=0x0042. iss and we to 5 in the same cycle → rbusy=1 and data written.
- NREAD=3, all ports ra=6 after writing 0xA5A5: all three rd=0xA5A5. Ports on 0, 6, 7 return 0x0000, 0xA5A5 and the stored m[7].
- clr pulse in IDLE with registers non-zero and pending set: ready=0 for 8 edges, writes during CLEAR are ignored, and afterwards all registers read 0 with all rbusy=0.
- Reset asserted at cnt=4 during CLEAR: ready stays 0 and the clear restarts. ready rises 7 edges after reset release.
